channel_readout_arbiter: RTL
============================

# channel_readout_arbiter

Round-robin arbiter that drains up to DATA_DEPTH channel readout buffers into a single DATA_WIDTH output stream. Each cycle it selects one requesting, enabled channel with a one-hot grant and pops one word from that channel. The word is steered through a one-hot mux into a registered output stage with a valid/ready handshake. The block sits between the per-channel TDC hit buffers and the trigger-matching / readout FIFO.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one channel word
- DATA_DEPTH, 8, number of channels (≥2)

Ports:
- clk  input  1  single clock domain; all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- chnl_enable  input  DATA_DEPTH  per-channel enable; 0 = channel never granted
- req  input  DATA_DEPTH  channel i has a word available (non-empty)
- data_in  input  DATA_WIDTH*DATA_DEPTH  packed channel words; channel i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- grant  output  DATA_DEPTH  one-hot pop strobe, at most one bit set; channel pops on the same edge
- data_out  output  DATA_WIDTH  registered selected word
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  downstream accepts data_out this cycle
- grant_id  output  log2(DATA_DEPTH)  registered index of the channel that sourced data_out

## Operation
- Eligible vector: elig = req & chnl_enable.
- Load condition: load = ~data_valid | data_ready, i.e. the output register is empty or being drained this cycle.
- grant is combinational:
  - When load and elig≠0: grant = one-hot of the first set bit of elig, searching upward from priority pointer ptr with wrap (ptr, ptr+1, …, DATA_DEPTH-1, 0, …, ptr-1).
  - Otherwise grant = 0.
  - grant is forced to 0 while rst=1.
- On an edge with grant≠0 (grant bit k):
  - data_out ← channel k word, selected by one-hot mux with grant as select
  - grant_id ← k
  - data_valid ← 1
  - ptr ← (k+1) mod DATA_DEPTH
- On an edge with data_valid & data_ready and no grant: data_valid ← 0. data_out and grant_id hold their last value.
- If data_valid & ~data_ready: data_out, grant_id and ptr hold, and grant = 0 (backpressure).
- ptr is unchanged when nothing is granted.
- A chnl_enable change takes effect in the same cycle's arbitration. It does not affect a word already in the output register.
- A channel whose req drops is simply skipped. No state is kept per channel.
- Reset values: ptr=0, data_valid=0, data_out=0, grant_id=0, grant=0.
- Reset during backpressure discards the held word. The channel it came from is not re-requested.
- No explicit FSM. The two states are EMPTY (data_valid=0) and FULL (data_valid=1):
  - EMPTY→FULL on grant.
  - FULL→FULL on grant with data_ready, or on ~data_ready.
  - FULL→EMPTY on data_ready with no grant.

## Timing
- req to grant: 0 cycles (combinational).
- grant to data_valid/data_out: 1 cycle.
- Throughput: one word per cycle while data_ready=1 and elig≠0.
- Fairness: with all channels continuously eligible and data_ready=1, the grant sequence is 0,1,…,DATA_DEPTH-1,0,… Worst-case wait for an eligible channel is DATA_DEPTH-1 grants.
- Simultaneous drain and load in one cycle keeps data_valid=1 with no bubble.
- Critical path: ptr → rotate/priority → grant → mux → data_out register. For DATA_DEPTH>16, a pipelined variant is a separate block, not a parameter of this one.

## Structure
- Shared header (tdc_pkg.vh) holds a clog2 function, used to size ptr and grant_id.
- Sub-module rr_onehot_pick (DATA_DEPTH): inputs elig and ptr, output one-hot pick. Implementation is a double-width rotate, then find-first-set, then un-rotate. Purely combinational, unit-testable alone.
- Data steering instantiates the existing one_hot_select mux with DATA_WIDTH/DATA_DEPTH passed through and grant as one_hot_code.
- Top level contains only the output register, ptr register and load logic.

## Test plan
- Reset → ptr=0, data_valid=0, grant=0, data_out=0, even with req=8'hFF held during reset.
- req=8'hFF, chnl_enable=8'hFF, data_ready=1 constant, data_in word i = 32'hA000_000i → grants 0..7 then 0, data_out = A0000000…A0000007 on consecutive cycles, no gaps.
- req=8'b1000_0100, ptr=3 → grant=8'b1000_0000 (ch7). Next cycle grant=ch2 with wrap, ptr becomes 3 again.
- Backpressure: fill with ch1 word 32'h1111_1111, data_ready=0 for 5 cycles → grant=0, data_out stable, data_valid=1. When data_ready rises, the next eligible channel is granted in the same cycle.
- chnl_enable=8'b1111_1110, req=8'h01 → no grant ever, data_valid stays 0. Setting enable bit 0 gives a grant of ch0 in that same cycle.
- Assert rst while data_valid=1, data_ready=0 → next cycle data_valid=0 and ptr=0. After release, arbitration restarts from ch0.

Source files
------------

// File: rtl/channel_readout_arbiter_pkg.sv
// Shared helpers for the channel readout arbiter slice: width sizing for
// channel indices and the output-stage occupancy encoding.
package channel_readout_arbiter_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/channel_readout_arbiter_mux.sv
// One-hot select mux: ORs together the channel words whose select bit is set.
module one_hot_select #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 8
) (
    input  logic [DATA_DEPTH-1:0]            one_hot_code,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0]            data_out
);

    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
            if (one_hot_code[i]) begin
                data_out = data_out | data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/channel_readout_arbiter_pick.sv
// Round-robin one-hot picker: rotate eligibility so ptr sits at bit 0,
// isolate the lowest set bit, then rotate the pick back to channel order.
module rr_onehot_pick
    import channel_readout_arbiter_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = 8
) (
    input  logic [DATA_DEPTH-1:0]        elig,
    input  logic [clog2(DATA_DEPTH)-1:0] ptr,
    output logic [DATA_DEPTH-1:0]        pick
);

    logic [2*DATA_DEPTH-1:0] w_rot_dbl;
    logic [DATA_DEPTH-1:0]   w_rot;
    logic [DATA_DEPTH-1:0]   w_first;
    logic [2*DATA_DEPTH-1:0] w_unrot_dbl;

    assign w_rot_dbl   = {elig, elig} >> ptr;
    assign w_rot       = w_rot_dbl[DATA_DEPTH-1:0];
    // Two's-complement AND keeps only the lowest set bit.
    assign w_first     = w_rot & (-w_rot);
    assign w_unrot_dbl = {w_first, w_first} << ptr;
    assign pick        = w_unrot_dbl[2*DATA_DEPTH-1:DATA_DEPTH];

endmodule

// File: rtl/channel_readout_arbiter.sv
// Round-robin drain of per-channel TDC hit buffers into one registered
// valid/ready output stream; grant doubles as the channel pop strobe.
module channel_readout_arbiter
    import channel_readout_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_DEPTH-1:0]           chnl_enable,
    input  logic [DATA_DEPTH-1:0]           req,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in,
    output logic [DATA_DEPTH-1:0]           grant,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic [clog2(DATA_DEPTH)-1:0]    grant_id
);

    localparam int unsigned PW = clog2(DATA_DEPTH);

    logic [PW-1:0]         r_ptr;
    out_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [PW-1:0]         r_grant_id;

    logic [DATA_DEPTH-1:0] w_elig;
    logic [DATA_DEPTH-1:0] w_pick;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [PW-1:0]         w_idx;
    logic [PW-1:0]         w_ptr_next;

    assign w_elig = req & chnl_enable;
    assign w_load = (r_state == OUT_EMPTY) || data_ready;
    assign grant  = (rst || !w_load) ? '0 : w_pick;

    rr_onehot_pick #(
        .DATA_DEPTH(DATA_DEPTH)
    ) u_pick (
        .elig(w_elig),
        .ptr (r_ptr),
        .pick(w_pick)
    );

    one_hot_select #(
        .DATA_WIDTH(DATA_WIDTH),
        .DATA_DEPTH(DATA_DEPTH)
    ) u_sel (
        .one_hot_code(grant),
        .data_in     (data_in),
        .data_out    (w_sel_data)
    );

    always_comb begin
        w_idx = '0;
        for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
            if (grant[i]) begin
                w_idx = PW'(i);
            end
        end
    end

    // Explicit wrap keeps non-power-of-two channel counts correct.
    assign w_ptr_next = (w_idx == PW'(DATA_DEPTH - 1)) ? '0 : w_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_state    <= OUT_EMPTY;
            r_data_out <= '0;
            r_grant_id <= '0;
        end else if (|grant) begin
            r_ptr      <= w_ptr_next;
            r_state    <= OUT_FULL;
            r_data_out <= w_sel_data;
            r_grant_id <= w_idx;
        end else if ((r_state == OUT_FULL) && data_ready) begin
            r_state    <= OUT_EMPTY;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = (r_state == OUT_FULL);
    assign grant_id   = r_grant_id;

endmodule
